// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared pipeline definitions for the hazard/stall controller
package hazard_stall_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic ex_mem_write;
      logic if_id_flush;
      logic id_ex_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   // x0 is hardwired to zero, so a load targeting it never feeds a consumer.
   function automatic logic load_use_hazard(
      input logic       memread,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       uses_rs2
   );
      return memread && (rd != REG_ZERO) &&
             ((rd == rs1) || (uses_rs2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline-side signal bundle of the hazard/stall controller
interface hazard_stall_unit_if #(
   parameter int COUNT_W = 32
);
   logic [4:0]         if_id_reg_rs1;
   logic [4:0]         if_id_reg_rs2;
   logic               if_id_uses_rs2;
   logic               id_ex_memread;
   logic [4:0]         id_ex_reg_rd;
   logic               ex_branch_taken;
   logic               dmem_busy;
   logic               pc_write;
   logic               if_id_write;
   logic               id_ex_write;
   logic               ex_mem_write;
   logic               if_id_flush;
   logic               id_ex_bubble;
   logic [COUNT_W-1:0] stall_count;
   logic [COUNT_W-1:0] flush_count;
   logic [COUNT_W-1:0] freeze_count;

   modport master (
      output if_id_reg_rs1, if_id_reg_rs2, if_id_uses_rs2, id_ex_memread,
             id_ex_reg_rd, ex_branch_taken, dmem_busy,
      input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
             id_ex_bubble, stall_count, flush_count, freeze_count
   );

   modport slave (
      input  if_id_reg_rs1, if_id_reg_rs2, if_id_uses_rs2, id_ex_memread,
             id_ex_reg_rd, ex_branch_taken, dmem_busy,
      output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
             id_ex_bubble, stall_count, flush_count, freeze_count
   );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// rtl/hazard_stall_unit_sat_counter.sv - saturating event counter
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] q
);
   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + W'(1);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush/freeze controller for the 5-stage RV32 pipeline
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int COUNT_W          = 32
) (
   input  logic             clk,
   input  logic             reset,
   hazard_stall_unit_if.slave bus
);
   localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

   state_t     r_state;
   logic [1:0] r_bub_left;

   state_t     w_next_state;
   logic [1:0] w_next_bub;
   ctrl_t      w_ctrl;
   logic       w_luh;
   logic       w_inc_stall;
   logic       w_inc_flush;
   logic       w_inc_freeze;

   assign w_luh = load_use_hazard(bus.id_ex_memread, bus.id_ex_reg_rd,
                                  bus.if_id_reg_rs1, bus.if_id_reg_rs2,
                                  bus.if_id_uses_rs2);

   always_comb begin
      w_ctrl       = CTRL_RUN;
      w_next_state = r_state;
      w_next_bub   = r_bub_left;
      w_inc_stall  = 1'b0;
      w_inc_flush  = 1'b0;
      w_inc_freeze = 1'b0;
      if (reset) begin
         w_ctrl = CTRL_FREEZE;
      end else if (bus.dmem_busy) begin
         // EX is frozen too, so the branch and hazard are re-evaluated afterwards.
         w_ctrl       = CTRL_FREEZE;
         w_inc_freeze = 1'b1;
      end else if (bus.ex_branch_taken) begin
         // A pending load stall dies with its squashed consumer.
         w_ctrl       = CTRL_FLUSH;
         w_next_state = ST_RUN;
         w_next_bub   = 2'd0;
         w_inc_flush  = 1'b1;
      end else if (r_state == ST_RUN && w_luh) begin
         w_ctrl      = CTRL_BUBBLE;
         w_inc_stall = 1'b1;
         if (LOAD_USE_BUBBLES > 1) begin
            w_next_state = ST_LOAD_STALL;
            w_next_bub   = BUB_INIT;
         end
      end else if (r_state == ST_LOAD_STALL) begin
         w_ctrl      = CTRL_BUBBLE;
         w_inc_stall = 1'b1;
         w_next_bub  = r_bub_left - 2'd1;
         if (r_bub_left == 2'd1) begin
            w_next_state = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_bub_left <= 2'd0;
      end else begin
         r_state    <= w_next_state;
         r_bub_left <= w_next_bub;
      end
   end

   assign bus.pc_write     = w_ctrl.pc_write;
   assign bus.if_id_write  = w_ctrl.if_id_write;
   assign bus.id_ex_write  = w_ctrl.id_ex_write;
   assign bus.ex_mem_write = w_ctrl.ex_mem_write;
   assign bus.if_id_flush  = w_ctrl.if_id_flush;
   assign bus.id_ex_bubble = w_ctrl.id_ex_bubble;

   sat_counter #(.W(COUNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc_stall),
      .q     (bus.stall_count)
   );

   sat_counter #(.W(COUNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc_flush),
      .q     (bus.flush_count)
   );

   sat_counter #(.W(COUNT_W)) u_freeze_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc_freeze),
      .q     (bus.freeze_count)
   );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed bench for hazard_stall_unit with 1, 2 and 3 bubbles
module tb_hazard_stall_unit;

   localparam logic [5:0] E_RUN = 6'b111100;
   localparam logic [5:0] E_BUB = 6'b001101;
   localparam logic [5:0] E_FLS = 6'b111111;
   localparam logic [5:0] E_FRZ = 6'b000000;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1, rs2, rd;
   logic       uses_rs2, memread, br, busy;
   logic       sat_inc;
   logic [2:0] sat_q;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_stall_unit_if #(.COUNT_W(32)) bus1 ();
   hazard_stall_unit_if #(.COUNT_W(32)) bus2 ();
   hazard_stall_unit_if #(.COUNT_W(32)) bus3 ();

   assign bus1.if_id_reg_rs1 = rs1;  assign bus2.if_id_reg_rs1 = rs1;  assign bus3.if_id_reg_rs1 = rs1;
   assign bus1.if_id_reg_rs2 = rs2;  assign bus2.if_id_reg_rs2 = rs2;  assign bus3.if_id_reg_rs2 = rs2;
   assign bus1.if_id_uses_rs2 = uses_rs2;  assign bus2.if_id_uses_rs2 = uses_rs2;  assign bus3.if_id_uses_rs2 = uses_rs2;
   assign bus1.id_ex_memread = memread;  assign bus2.id_ex_memread = memread;  assign bus3.id_ex_memread = memread;
   assign bus1.id_ex_reg_rd = rd;  assign bus2.id_ex_reg_rd = rd;  assign bus3.id_ex_reg_rd = rd;
   assign bus1.ex_branch_taken = br;  assign bus2.ex_branch_taken = br;  assign bus3.ex_branch_taken = br;
   assign bus1.dmem_busy = busy;  assign bus2.dmem_busy = busy;  assign bus3.dmem_busy = busy;

   hazard_stall_unit #(.LOAD_USE_BUBBLES(1), .COUNT_W(32)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   hazard_stall_unit #(.LOAD_USE_BUBBLES(2), .COUNT_W(32)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
   hazard_stall_unit #(.LOAD_USE_BUBBLES(3), .COUNT_W(32)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

   sat_counter #(.W(3)) u_sat (.clk(clk), .reset(reset), .inc(sat_inc), .q(sat_q));

   logic [5:0]  ctl [3];
   logic [31:0] stc [3];
   logic [31:0] flc [3];
   logic [31:0] frc [3];

   assign ctl[0] = {bus1.pc_write, bus1.if_id_write, bus1.id_ex_write, bus1.ex_mem_write, bus1.if_id_flush, bus1.id_ex_bubble};
   assign ctl[1] = {bus2.pc_write, bus2.if_id_write, bus2.id_ex_write, bus2.ex_mem_write, bus2.if_id_flush, bus2.id_ex_bubble};
   assign ctl[2] = {bus3.pc_write, bus3.if_id_write, bus3.id_ex_write, bus3.ex_mem_write, bus3.if_id_flush, bus3.id_ex_bubble};
   assign stc[0] = bus1.stall_count;  assign stc[1] = bus2.stall_count;  assign stc[2] = bus3.stall_count;
   assign flc[0] = bus1.flush_count;  assign flc[1] = bus2.flush_count;  assign flc[2] = bus3.flush_count;
   assign frc[0] = bus1.freeze_count; assign frc[1] = bus2.freeze_count; assign frc[2] = bus3.freeze_count;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic [5:0] e1, input logic [5:0] e2, input logic [5:0] e3);
      #4;
      check({tag, " ctl b1"}, 64'(ctl[0]), 64'(e1));
      check({tag, " ctl b2"}, 64'(ctl[1]), 64'(e2));
      check({tag, " ctl b3"}, 64'(ctl[2]), 64'(e3));
      tick();
   endtask

   task automatic counts(input string tag, input int s1, input int s2, input int s3, input int fl, input int fr);
      check({tag, " stall b1"}, 64'(stc[0]), 64'(s1));
      check({tag, " stall b2"}, 64'(stc[1]), 64'(s2));
      check({tag, " stall b3"}, 64'(stc[2]), 64'(s3));
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s flush b%0d", tag, i + 1), 64'(flc[i]), 64'(fl));
         check($sformatf("%s freeze b%0d", tag, i + 1), 64'(frc[i]), 64'(fr));
      end
   endtask

   task automatic idle();
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
      uses_rs2 = 1'b0; memread = 1'b0; br = 1'b0; busy = 1'b0;
   endtask

   // lw x5 in EX, add x6,x5,x2 in ID
   task automatic lw_add();
      memread = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd2; uses_rs2 = 1'b1;
   endtask

   initial begin
      reset = 1'b1; sat_inc = 1'b0;
      idle();
      step("reset0", E_FRZ, E_FRZ, E_FRZ);
      step("reset1", E_FRZ, E_FRZ, E_FRZ);
      counts("after reset", 0, 0, 0, 0, 0);
      reset = 1'b0;
      step("idle", E_RUN, E_RUN, E_RUN);

      // load-use: bubble count follows LOAD_USE_BUBBLES
      lw_add();
      step("luh c0", E_BUB, E_BUB, E_BUB);
      memread = 1'b0; rd = 5'd0;
      step("luh c1", E_RUN, E_BUB, E_BUB);
      step("luh c2", E_RUN, E_RUN, E_BUB);
      step("luh c3", E_RUN, E_RUN, E_RUN);
      counts("luh", 1, 2, 3, 0, 0);

      // x0 destination and masked rs2 never stall
      memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd2; uses_rs2 = 1'b1;
      step("x0 dest", E_RUN, E_RUN, E_RUN);
      rd = 5'd5; rs1 = 5'd9; rs2 = 5'd5; uses_rs2 = 1'b0;
      step("rs2 masked", E_RUN, E_RUN, E_RUN);
      uses_rs2 = 1'b1;
      step("rs2 used", E_BUB, E_BUB, E_BUB);
      idle();
      repeat (3) tick();
      counts("rs2", 2, 4, 6, 0, 0);

      // branch beats a simultaneous load-use
      lw_add(); br = 1'b1;
      step("br+luh", E_FLS, E_FLS, E_FLS);
      idle();
      step("after br", E_RUN, E_RUN, E_RUN);
      counts("br", 2, 4, 6, 1, 0);

      // freeze during LOAD_STALL, branch ignored while frozen
      lw_add();
      step("frz luh", E_BUB, E_BUB, E_BUB);
      idle(); busy = 1'b1; br = 1'b1;
      step("frz c0", E_FRZ, E_FRZ, E_FRZ);
      br = 1'b0;
      step("frz c1", E_FRZ, E_FRZ, E_FRZ);
      step("frz c2", E_FRZ, E_FRZ, E_FRZ);
      busy = 1'b0;
      step("post frz0", E_RUN, E_BUB, E_BUB);
      step("post frz1", E_RUN, E_RUN, E_BUB);
      step("post frz2", E_RUN, E_RUN, E_RUN);
      counts("freeze", 3, 6, 9, 1, 3);

      // reset in the middle of LOAD_STALL
      lw_add();
      step("rst luh", E_BUB, E_BUB, E_BUB);
      idle(); reset = 1'b1;
      step("rst mid", E_FRZ, E_FRZ, E_FRZ);
      reset = 1'b0;
      step("rst after", E_RUN, E_RUN, E_RUN);
      counts("rst", 0, 0, 0, 0, 0);

      // saturation on a narrow counter
      sat_inc = 1'b1;
      repeat (6) tick();
      check("sat six", 64'(sat_q), 64'd6);
      repeat (3) tick();
      check("sat hold", 64'(sat_q), 64'd7);
      tick();
      check("sat hold2", 64'(sat_q), 64'd7);
      sat_inc = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
